// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Arbitrates dcache (load/store) and icache (line fetch) requests onto the
//   single proc2mem port, records which cache owns each outstanding load tag,
//   and steers returning memory tags back to the owning cache.
//
// Optional feature macro: MEM_ARB_ANTI_STARVE_EN
//   defined   -> icache starvation counter; icache takes priority after
//                STARVE_LIMIT consecutive denied cycles.
//   undefined -> strict dcache priority, no counter, STARVE_LIMIT unused.
//
// Ports
//   clock                    system clock
//   reset                    active-low asynchronous reset
//   icache_req_addr          {valid, addr[31:0]} icache line request
//   icache_req_accepted      icache request taken this cycle
//   dcache_req_valid/cmd/addr/data   dcache request
//   dcache_req_accepted      dcache request taken this cycle
//   proc2mem_command/addr/data       granted request to memory
//                            (command: 0 = NONE, 1 = LOAD, 2 = STORE)
//   mem2proc_transaction_tag same-cycle tag from memory, 0 = rejected
//   mem2proc_data_tag        tag of returning data, 0 = none
//   mem2proc_data            returning data
//   current_req_tag          accepted tag, broadcast to both caches
//   icache_data_tag          returning tag when owned by icache, else 0
//   dcache_data_tag          returning tag when owned by dcache, else 0
//   mem_data                 mem2proc_data passthrough
module mem_req_arbiter #(
    parameter int unsigned NUM_TAGS     = 15,
    parameter int unsigned STARVE_LIMIT = 8,
    localparam int unsigned TAG_W       = $clog2(NUM_TAGS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [32:0]      icache_req_addr,
    output logic             icache_req_accepted,
    input  logic             dcache_req_valid,
    input  logic [1:0]       dcache_req_cmd,
    input  logic [31:0]      dcache_req_addr,
    input  logic [63:0]      dcache_req_data,
    output logic             dcache_req_accepted,
    output logic [1:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    input  logic [TAG_W-1:0] mem2proc_transaction_tag,
    input  logic [TAG_W-1:0] mem2proc_data_tag,
    input  logic [63:0]      mem2proc_data,
    output logic [TAG_W-1:0] current_req_tag,
    output logic [TAG_W-1:0] icache_data_tag,
    output logic [TAG_W-1:0] dcache_data_tag,
    output logic [63:0]      mem_data
);

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_cmd_e;

    localparam int unsigned TAG_SPACE = 1 << TAG_W;

    // Owner table sized to the full tag space; entry 0 is never allocated.
    logic [TAG_SPACE-1:0] tag_valid;
    logic [TAG_SPACE-1:0] tag_owner;   // 1 = icache, 0 = dcache

    logic icache_valid;
    logic icache_priority;
    logic grant_d;
    logic grant_i;
    logic tag_ok;
    logic alloc_load;
    logic ret_hit;

    assign icache_valid = icache_req_addr[32];

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign icache_priority = icache_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts consecutive denied icache cycles; a memory rejection while the
    // icache holds priority leaves the count saturated so priority persists.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!icache_valid || icache_req_accepted) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign icache_priority = 1'b0;
`endif

    // Grants are gated by reset so all request-side outputs are quiet in reset.
    assign grant_d = reset && dcache_req_valid && !icache_priority;
    assign grant_i = reset && icache_valid && !grant_d;
    assign tag_ok  = (mem2proc_transaction_tag != '0);

    assign dcache_req_accepted = grant_d && tag_ok;
    assign icache_req_accepted = grant_i && tag_ok;
    assign current_req_tag     = reset ? mem2proc_transaction_tag : '0;

    assign alloc_load = tag_ok &&
        (grant_i || (grant_d && (dcache_req_cmd == MEM_LOAD)));

    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_d) begin
            proc2mem_command = dcache_req_cmd;
            proc2mem_addr    = dcache_req_addr;
            if (dcache_req_cmd == MEM_STORE) begin
                proc2mem_data = dcache_req_data;
            end
        end else if (grant_i) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = icache_req_addr[31:0];
        end
    end

    // Returns are routed only for live, in-range tags; anything else is dropped.
    assign ret_hit = reset && (mem2proc_data_tag != '0) &&
                     (mem2proc_data_tag <= TAG_W'(NUM_TAGS)) &&
                     tag_valid[mem2proc_data_tag];

    assign icache_data_tag = (ret_hit &&  tag_owner[mem2proc_data_tag]) ? mem2proc_data_tag : '0;
    assign dcache_data_tag = (ret_hit && !tag_owner[mem2proc_data_tag]) ? mem2proc_data_tag : '0;
    assign mem_data        = mem2proc_data;

    // Clear precedes set so a tag returned and re-issued in the same cycle
    // ends up owned by the new requester.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            if (ret_hit) begin
                tag_valid[mem2proc_data_tag] <= 1'b0;
            end
            if (alloc_load) begin
                tag_valid[mem2proc_transaction_tag] <= 1'b1;
                tag_owner[mem2proc_transaction_tag] <= grant_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int NT  = 15;
    localparam int TW  = 4;
    localparam int LIM = 8;
`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [32:0]   icache_req_addr;
    logic          icache_req_accepted;
    logic          dcache_req_valid;
    logic [1:0]    dcache_req_cmd;
    logic [31:0]   dcache_req_addr;
    logic [63:0]   dcache_req_data;
    logic          dcache_req_accepted;
    logic [1:0]    proc2mem_command;
    logic [31:0]   proc2mem_addr;
    logic [63:0]   proc2mem_data;
    logic [TW-1:0] mem2proc_transaction_tag;
    logic [TW-1:0] mem2proc_data_tag;
    logic [63:0]   mem2proc_data;
    logic [TW-1:0] current_req_tag;
    logic [TW-1:0] icache_data_tag;
    logic [TW-1:0] dcache_data_tag;
    logic [63:0]   mem_data;

    always #5 clock = ~clock;

    mem_req_arbiter #(.NUM_TAGS(NT), .STARVE_LIMIT(LIM)) dut (
        .clock(clock),
        .reset(reset),
        .icache_req_addr(icache_req_addr),
        .icache_req_accepted(icache_req_accepted),
        .dcache_req_valid(dcache_req_valid),
        .dcache_req_cmd(dcache_req_cmd),
        .dcache_req_addr(dcache_req_addr),
        .dcache_req_data(dcache_req_data),
        .dcache_req_accepted(dcache_req_accepted),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data_tag(mem2proc_data_tag),
        .mem2proc_data(mem2proc_data),
        .current_req_tag(current_req_tag),
        .icache_data_tag(icache_data_tag),
        .dcache_data_tag(dcache_data_tag),
        .mem_data(mem_data)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: which cache owns each tag (-1 none, 0 dcache, 1 icache)
    // and how many consecutive cycles the icache has been turned away.
    int owner [16];
    int denied;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) owner[i] = -1;
        denied = 0;
    endtask

    // Compare every output against the model for the current inputs, then
    // advance the model to what must hold after the coming clock edge.
    task automatic model_check();
        bit iv, starved, dg, ig, tok, hit;
        int rt, tt;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [TW-1:0] e_it, e_dt;
        iv = icache_req_addr[32];
        rt = int'(mem2proc_data_tag);
        tt = int'(mem2proc_transaction_tag);
        chk("mem_data", mem_data, mem2proc_data);
        if (!reset) begin
            model_reset();
            chk("rst_cmd", {62'd0, proc2mem_command}, 64'd0);
            chk("rst_iacc", {63'd0, icache_req_accepted}, 64'd0);
            chk("rst_dacc", {63'd0, dcache_req_accepted}, 64'd0);
            chk("rst_ctag", {60'd0, current_req_tag}, 64'd0);
            chk("rst_itag", {60'd0, icache_data_tag}, 64'd0);
            chk("rst_dtag", {60'd0, dcache_data_tag}, 64'd0);
            return;
        end
        starved = ANTI && iv && (denied >= LIM);
        dg  = dcache_req_valid && !starved;
        ig  = iv && !dg;
        tok = (tt != 0);
        e_cmd = 2'd0; e_addr = '0; e_data = '0;
        if (dg) begin
            e_cmd = dcache_req_cmd; e_addr = dcache_req_addr;
            if (dcache_req_cmd == 2'd2) e_data = dcache_req_data;
        end else if (ig) begin
            e_cmd = 2'd1; e_addr = icache_req_addr[31:0];
        end
        hit  = (rt != 0) && (owner[rt] >= 0);
        e_it = (hit && owner[rt] == 1) ? TW'(rt) : '0;
        e_dt = (hit && owner[rt] == 0) ? TW'(rt) : '0;
        chk("cmd",  {62'd0, proc2mem_command}, {62'd0, e_cmd});
        chk("addr", {32'd0, proc2mem_addr}, {32'd0, e_addr});
        chk("data", proc2mem_data, e_data);
        chk("iacc", {63'd0, icache_req_accepted}, {63'd0, ig && tok});
        chk("dacc", {63'd0, dcache_req_accepted}, {63'd0, dg && tok});
        chk("ctag", {60'd0, current_req_tag}, {60'd0, mem2proc_transaction_tag});
        chk("itag", {60'd0, icache_data_tag}, {60'd0, e_it});
        chk("dtag", {60'd0, dcache_data_tag}, {60'd0, e_dt});
        if (hit) owner[rt] = -1;
        if (tok && ig) owner[tt] = 1;
        else if (tok && dg && dcache_req_cmd == 2'd1) owner[tt] = 0;
        if (iv && !(ig && tok)) denied = (denied + 1 > LIM) ? LIM : denied + 1;
        else denied = 0;
    endtask

    task automatic idle_inputs();
        icache_req_addr = '0; dcache_req_valid = 0; dcache_req_cmd = 2'd0;
        dcache_req_addr = '0; dcache_req_data = '0;
        mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
    endtask

    task automatic settle(); #2; model_check(); endtask
    task automatic next();   @(negedge clock); endtask

    int first_grant;

    initial begin
        model_reset();
        reset = 1'b0;
        idle_inputs();
        dcache_req_valid = 1; dcache_req_cmd = 2'd1; mem2proc_transaction_tag = 4'd7;
        @(negedge clock);
        settle();
        chk("lit_rst_dacc", {63'd0, dcache_req_accepted}, 64'd0);
        next();
        reset = 1'b1; idle_inputs();
        settle(); chk("lit_idle_cmd", {62'd0, proc2mem_command}, 64'd0); next();

        // both valid, dcache load, tag 3
        icache_req_addr = {1'b1, 32'h0000_1000};
        dcache_req_valid = 1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h0000_2000;
        mem2proc_transaction_tag = 4'd3;
        settle();
        chk("lit_t1_dacc", {63'd0, dcache_req_accepted}, 64'd1);
        chk("lit_t1_iacc", {63'd0, icache_req_accepted}, 64'd0);
        chk("lit_t1_addr", {32'd0, proc2mem_addr}, 64'h2000);
        next();

        // icache alone, tag 5
        idle_inputs(); icache_req_addr = {1'b1, 32'h0000_3000}; mem2proc_transaction_tag = 4'd5;
        settle();
        chk("lit_t2_iacc", {63'd0, icache_req_accepted}, 64'd1);
        chk("lit_t2_cmd", {62'd0, proc2mem_command}, 64'd1);
        chk("lit_t2_addr", {32'd0, proc2mem_addr}, 64'h3000);
        next();
        idle_inputs(); mem2proc_data_tag = 4'd5;
        settle();
        chk("lit_t2_itag", {60'd0, icache_data_tag}, 64'd5);
        chk("lit_t2_dtag", {60'd0, dcache_data_tag}, 64'd0);
        next();
        idle_inputs(); mem2proc_data_tag = 4'd5;
        settle(); chk("lit_t2_cleared", {60'd0, icache_data_tag}, 64'd0); next();
        idle_inputs(); mem2proc_data_tag = 4'd3;
        settle(); chk("lit_t1_ret", {60'd0, dcache_data_tag}, 64'd3); next();

        // dcache store, tag 2, then return tag 2
        idle_inputs(); dcache_req_valid = 1; dcache_req_cmd = 2'd2;
        dcache_req_addr = 32'h40; dcache_req_data = 64'hDEAD_BEEF_0123_4567;
        mem2proc_transaction_tag = 4'd2;
        settle(); chk("lit_t3_data", proc2mem_data, 64'hDEAD_BEEF_0123_4567); next();
        idle_inputs(); mem2proc_data_tag = 4'd2;
        settle();
        chk("lit_t3_itag", {60'd0, icache_data_tag}, 64'd0);
        chk("lit_t3_dtag", {60'd0, dcache_data_tag}, 64'd0);
        next();

        // memory rejects three times
        for (int c = 0; c < 3; c++) begin
            idle_inputs(); dcache_req_valid = 1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'h80;
            settle(); chk("lit_t4_dacc", {63'd0, dcache_req_accepted}, 64'd0); next();
        end

        // return tag 4 while re-issuing tag 4 to icache, then reset
        idle_inputs(); dcache_req_valid = 1; dcache_req_cmd = 2'd1; mem2proc_transaction_tag = 4'd4;
        settle(); next();
        idle_inputs(); icache_req_addr = {1'b1, 32'h500}; mem2proc_transaction_tag = 4'd4;
        mem2proc_data_tag = 4'd4;
        settle();
        chk("lit_t5_dtag", {60'd0, dcache_data_tag}, 64'd4);
        chk("lit_t5_iacc", {63'd0, icache_req_accepted}, 64'd1);
        next();
        idle_inputs(); reset = 1'b0;
        settle(); next();
        reset = 1'b1; mem2proc_data_tag = 4'd4;
        settle();
        chk("lit_t5_drop_i", {60'd0, icache_data_tag}, 64'd0);
        chk("lit_t5_drop_d", {60'd0, dcache_data_tag}, 64'd0);
        next();

        // starvation under continuous dcache loads
        first_grant = 0;
        for (int c = 1; c <= 20; c++) begin
            idle_inputs(); icache_req_addr = {1'b1, 32'h900};
            dcache_req_valid = 1; dcache_req_cmd = 2'd1; dcache_req_addr = 32'hA00;
            mem2proc_transaction_tag = TW'((c % NT) + 1);
            settle();
            if (icache_req_accepted && first_grant == 0) first_grant = c;
            next();
        end
        chk("lit_starve_cycle", 64'(first_grant), ANTI ? 64'd9 : 64'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            icache_req_addr  = {($urandom_range(0, 2) != 0), $urandom()};
            dcache_req_valid = ($urandom_range(0, 3) != 0);
            dcache_req_cmd   = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2;
            dcache_req_addr  = $urandom();
            dcache_req_data  = {$urandom(), $urandom()};
            mem2proc_transaction_tag = ($urandom_range(0, 4) == 0) ? '0 : TW'($urandom_range(1, NT));
            mem2proc_data_tag        = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, NT));
            mem2proc_data            = {$urandom(), $urandom()};
            settle();
            next();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
